// File: rtl/sic4_multicycle_core.sv
// Multi-cycle SIC-4 core: PC/IR/alu_q/mdr datapath sequenced by an FSM, req/ack memories.
// Define SIC4_SIGNED_IMM_EN to sign-extend the 2-bit immediate (default: zero-extend).
module sic4_multicycle_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retire,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  localparam int unsigned IR_W  = 8;
  localparam int unsigned NREGS = 4;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_t;

  state_t            state, state_nxt;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] alu_q, mdr, alu_c, imm_c;
  logic [DATA_W-1:0] regs [NREGS];
  logic [1:0]        op, rtd, rs, fun;
  logic              ir_ld, alu_ld, mdr_ld, wb_en;

  assign op  = ir[7:6];
  assign rtd = ir[5:4];
  assign rs  = ir[3:2];
  assign fun = ir[1:0];

`ifdef SIC4_SIGNED_IMM_EN
  assign imm_c = {{(DATA_W-2){fun[1]}}, fun};
`else
  assign imm_c = DATA_W'(fun);
`endif

  assign rs_data    = regs[rs];
  assign rt_data    = regs[rtd];
  assign imem_addr  = pc;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = rt_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next state and handshake/strobe decode; rst gates imem_req so it drops immediately
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    ir_ld     = 1'b0;
    alu_ld    = 1'b0;
    mdr_ld    = 1'b0;
    wb_en     = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (run && !rst) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_ld     = 1'b1;
            state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_ld    = 1'b1;
        state_nxt = op[1] ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = op[0];
        if (dmem_ack) begin
          mdr_ld    = !op[0];
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        retire    = 1'b1;
        wb_en     = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // ALU: R-type functions, otherwise rs + imm (addi and effective address)
  always_comb begin
    alu_c = rs_data + imm_c;
    if (op == 2'b00) begin
      unique case (fun)
        2'b00: alu_c = rs_data + rt_data;
        2'b01: alu_c = rs_data - rt_data;
        2'b10: alu_c = rs_data & rt_data;
        2'b11: alu_c = rs_data | rt_data;
        default: alu_c = rs_data + rt_data;
      endcase
    end
  end

  // Datapath registers and register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      ir    <= '0;
      alu_q <= '0;
      mdr   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (ir_ld)  ir    <= imem_data;
      if (alu_ld) alu_q <= alu_c;
      if (mdr_ld) mdr   <= dmem_rdata;
      if (wb_en) begin
        if (op != 2'b11) regs[rtd] <= (op == 2'b10) ? mdr : alu_q;
        pc <= pc + PC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sic4_multicycle_core.sv
// Randomized bench for sic4_multicycle_core: wait-state memories, instruction-level model, per-cycle compare.
module tb_sic4_multicycle_core;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 8;
`ifdef SIC4_SIGNED_IMM_EN
  localparam logic [7:0] IMM3 = 8'hFF;
`else
  localparam logic [7:0] IMM3 = 8'h03;
`endif

  logic          clk = 1'b0;
  logic          rst, run;
  logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire;
  logic [PW-1:0] imem_addr, pc;
  logic [7:0]    imem_data;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata, rs_data, rt_data;

  sic4_multicycle_core #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retire(retire), .pc(pc), .rs_data(rs_data), .rt_data(rt_data)
  );

  always #5 clk = ~clk;

  // Memories seen by the DUT, plus the model's architectural state
  logic [7:0] imem    [256];
  logic [7:0] tb_dmem [256];
  logic [7:0] m_dmem  [256];
  logic [7:0] m_regs  [4];
  logic [7:0] m_pc;

  int n_chk = 0, n_pass = 0;
  int max_wait = 0, wfix = 0;
  bit hold_d = 0, chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] imm_of(input logic [1:0] f);
`ifdef SIC4_SIGNED_IMM_EN
    return {{6{f[1]}}, f};
`else
    return {6'b0, f};
`endif
  endfunction

  function automatic logic [7:0] ea_of(input logic [7:0] ins);
    return m_regs[ins[3:2]] + imm_of(ins[1:0]);
  endfunction

  // Architectural effect of one instruction
  task automatic model_exec(input logic [7:0] ins);
    logic [7:0] a, b;
    a = m_regs[ins[3:2]];
    b = m_regs[ins[5:4]];
    case (ins[7:6])
      2'b00: case (ins[1:0])
               2'b00: m_regs[ins[5:4]] = a + b;
               2'b01: m_regs[ins[5:4]] = a - b;
               2'b10: m_regs[ins[5:4]] = a & b;
               default: m_regs[ins[5:4]] = a | b;
             endcase
      2'b01: m_regs[ins[5:4]] = a + imm_of(ins[1:0]);
      2'b10: m_regs[ins[5:4]] = m_dmem[ea_of(ins)];
      default: m_dmem[ea_of(ins)] = b;
    endcase
  endtask

  // Memory responder: random or fixed wait states, random acks while req is low
  int  i_left, d_left;
  bit  i_pend, d_pend;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      i_pend = 0; d_pend = 0; imem_ack = 1'b0; dmem_ack = 1'b0;
    end else begin
      if (imem_req) begin
        if (!i_pend) begin
          i_pend = 1;
          i_left = (wfix >= 0) ? wfix : $urandom_range(0, max_wait);
        end
        if (i_left == 0) begin
          imem_ack = 1'b1; imem_data = imem[imem_addr]; i_pend = 0;
        end else begin
          imem_ack = 1'b0; imem_data = 8'($urandom); i_left--;
        end
      end else begin
        imem_ack = 1'($urandom_range(0, 1)); imem_data = 8'($urandom);
      end
      if (dmem_req) begin
        if (!d_pend) begin
          d_pend = 1;
          d_left = (wfix >= 0) ? wfix : $urandom_range(0, max_wait);
        end
        if (d_left == 0 && !hold_d) begin
          dmem_ack = 1'b1; d_pend = 0;
          if (dmem_we) tb_dmem[dmem_addr] = dmem_wdata;
          else         dmem_rdata = tb_dmem[dmem_addr];
        end else begin
          dmem_ack = 1'b0; dmem_rdata = 8'($urandom);
          if (d_left > 0) d_left--;
        end
      end else begin
        dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = 8'($urandom);
      end
    end
  end

  // Compare process state
  int         cyc_n, start_c, waits, last_lat, n_ret;
  int         ret_cyc [8];
  bit         inflight, post_chk, wrap_pend, wrap_seen;
  logic [1:0] post_rtd;
  bit         pi_wait, pd_wait, pd_we;
  logic [7:0] pi_addr, pd_addr, pd_wdata;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_pc = 8'h00; n_ret = 0; cyc_n = 0; inflight = 0; post_chk = 0;
    wrap_pend = 0; pi_wait = 0; pd_wait = 0;
  endtask

  always @(negedge clk) begin
    logic [7:0] cur;
    if (chk_en && !rst) begin
      cyc_n++;
      cur = imem[m_pc];
      chk("pc", 32'(pc), 32'(m_pc));
      if (!run) chk("imem_req_idle", 32'(imem_req), 32'd0);
      if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("req_overlap", 32'(imem_req & dmem_req), 32'd0);
      if (pi_wait) begin
        chk("imem_req_hold", 32'(imem_req), 32'd1);
        chk("imem_addr_hold", 32'(imem_addr), 32'(pi_addr));
      end
      if (pd_wait) begin
        chk("dmem_req_hold", 32'(dmem_req), 32'd1);
        chk("dmem_addr_hold", 32'(dmem_addr), 32'(pd_addr));
        chk("dmem_we_hold", 32'(dmem_we), 32'(pd_we));
        chk("dmem_wdata_hold", 32'(dmem_wdata), 32'(pd_wdata));
      end
      if (!inflight && imem_req) begin
        inflight = 1; start_c = cyc_n; waits = 0;
      end
      if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) waits++;
      if (dmem_req) begin
        chk("dmem_for_memop", 32'(cur[7]), 32'd1);
        chk("dmem_addr", 32'(dmem_addr), 32'(ea_of(cur)));
        chk("dmem_we", 32'(dmem_we), 32'(cur[6]));
        if (cur[6]) chk("dmem_wdata", 32'(dmem_wdata), 32'(m_regs[cur[5:4]]));
      end
      if (post_chk) begin
        chk("rt_after_wb", 32'(rt_data), 32'(m_regs[post_rtd]));
        if (wrap_pend) wrap_seen = (pc == 8'h00);
        post_chk = 0; wrap_pend = 0;
      end
      if (retire) begin
        chk("rs_data", 32'(rs_data), 32'(m_regs[cur[3:2]]));
        chk("rt_data", 32'(rt_data), 32'(m_regs[cur[5:4]]));
        chk("retire_inflight", 32'(inflight), 32'd1);
        chk("latency", 32'(cyc_n - start_c), 32'((cur[7] ? 3 : 2) + waits));
        last_lat = cyc_n - start_c + 1;
        wrap_pend = (pc == 8'hFF);
        model_exec(cur);
        m_pc = m_pc + 8'd1;
        post_rtd = cur[5:4]; post_chk = 1; inflight = 0;
        if (n_ret < 8) ret_cyc[n_ret] = cyc_n;
        n_ret++;
      end
      pi_wait = imem_req && !imem_ack; pi_addr = imem_addr;
      pd_wait = dmem_req && !dmem_ack; pd_addr = dmem_addr;
      pd_we = dmem_we; pd_wdata = dmem_wdata;
    end
  end

  task automatic wait_ret(input int target);
    int b = 0;
    while (n_ret < target && b < 500) begin
      @(posedge clk); #1; b++;
    end
    chk("retire_count", 32'(n_ret), 32'(target));
    run = 1'b0;
  endtask

  initial begin
    int b, seen;
    rst = 1'b1; run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_data = 8'h00; dmem_rdata = 8'h00; wrap_seen = 0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      tb_dmem[i] = 8'($urandom); m_dmem[i] = tb_dmem[i]; imem[i] = 8'h00;
    end
    imem[0] = 8'h41; imem[1] = 8'h51; imem[2] = 8'h14; imem[3] = 8'hC4; imem[4] = 8'hA5;
    tb_dmem[5] = 8'h5A; m_dmem[5] = 8'h5A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    chk("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_rs_data", 32'(rs_data), 32'd0);
    chk("rst_rt_data", 32'(rt_data), 32'd0);

    // ALU sequence then store/load, zero-wait memories
    @(posedge clk); #1;
    rst = 1'b0; model_reset(); chk_en = 1;
    wait_ret(5);
    repeat (3) @(posedge clk);
    #1;
    chk("ret_cycle_1", 32'(ret_cyc[0]), 32'd3);
    chk("ret_cycle_2", 32'(ret_cyc[1]), 32'd6);
    chk("ret_cycle_3", 32'(ret_cyc[2]), 32'd9);
    chk("ret_cycle_5", 32'(ret_cyc[4]), 32'd17);
    chk("pc_after_5", 32'(pc), 32'd5);
    chk("store_mem4", 32'(tb_dmem[4]), 32'h01);
    chk("load_r2", 32'(rt_data), 32'h5A);
    chk("model_r1", 32'(m_regs[1]), 32'h04);

    // Reset while a store waits in MEM
    imem[5] = 8'hC4; hold_d = 1; run = 1'b1;
    b = 0;
    while (!dmem_req && b < 50) begin
      @(posedge clk); #1; b++;
    end
    chk("dmem_req_reached", 32'(dmem_req), 32'd1);
    chk_en = 0; rst = 1'b1;
    #1;
    chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
    chk("midrst_imem_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_rs", 32'(rs_data), 32'd0);
    chk("midrst_rt", 32'(rt_data), 32'd0);
    hold_d = 0;
    imem[0] = 8'h51; imem[1] = 8'h11; imem[2] = 8'h43; imem[3] = 8'hC4;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; model_reset(); chk_en = 1;
    @(negedge clk);
    chk("first_fetch_req", 32'(imem_req), 32'd1);
    chk("first_fetch_addr", 32'(imem_addr), 32'd0);

    // Subtract wrap and immediate extension
    wait_ret(3);
    @(posedge clk); #1;
    chk("imm_r0_rt", 32'(rt_data), 32'(IMM3));
    chk("imm_r0_rs", 32'(rs_data), 32'(IMM3));
    chk("model_wrap_r1", 32'(m_regs[1]), 32'hFF);

    // Store with 3 wait cycles on each memory
    wfix = 3; run = 1'b1;
    wait_ret(4);
    chk("wait_latency", 32'(last_lat), 32'd10);
    chk("store_mem_ff", 32'(tb_dmem[255]), 32'(IMM3));

    // Random programs, random waits, random run gaps
    wfix = -1; max_wait = 3;
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
    seen = n_ret; run = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      if (n_ret != seen) begin
        seen = n_ret;
        run = ($urandom_range(0, 3) != 0);
      end else if (!run) begin
        run = 1'($urandom_range(0, 1));
      end
    end
    chk_en = 0;
    chk("pc_wrap", 32'(wrap_seen), 32'd1);
    chk("random_progress", 32'(n_ret > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sic4_multicycle_core.md
# sic4_multicycle_core

Parametrised multi-cycle successor to the single-cycle SIC-4 datapath. It executes the same 8-bit SIC-4 instruction format with a configurable data width and a PC/IR/ALU-result register pipeline sequenced by an FSM. Instruction and data memories are external and reached through req/ack handshakes, so wait-state memories work. It sits between the top level and the memory blocks, replacing the single-cycle datapath and its combinational control unit.

## Interface
- DATA_W, 8, register/ALU/data-memory word width (≥4)
- PC_W, 8, program counter and instruction address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  permits new instruction fetch
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  8  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_addr  out  DATA_W  data address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads
- dmem_rdata  in  DATA_W  load data
- retire  out  1  one-cycle pulse per completed instruction
- pc  out  PC_W  current program counter
- rs_data  out  DATA_W  regfile read port 1 (IR rs field)
- rt_data  out  DATA_W  regfile read port 2 (IR rtd field)

## Operation
- IR fields: [7:6] op, [5:4] rtd, [3:2] rs, [1:0] fun_imm. Four registers r0–r3, each DATA_W wide.
- op 00 R-type: rtd = rs OP rtd. funct 00 add, 01 sub (rs − rtd), 10 and, 11 or.
- op 01 addi: rtd = rs + imm.
- op 10 load: rtd = mem[rs + imm].
- op 11 store: mem[rs + imm] = rtd. No register write.
- imm is fun_imm extended to DATA_W (see Configuration). All arithmetic is mod 2^DATA_W. There are no flags.
- FSM states:
  - FETCH: if run, assert imem_req. On imem_ack, latch IR and go to EXEC. If run=0, hold with imem_req=0.
  - EXEC: latch ALU result into alu_q. Go to MEM for op 1x, otherwise to WB.
  - MEM: assert dmem_req with dmem_addr=alu_q and dmem_wdata=rt_data; dmem_we=op[0]. On dmem_ack, latch dmem_rdata into mdr if load, then go to WB.
  - WB: write alu_q (ALU ops) or mdr (load) to rtd. Set pc ← pc+1, wrapping mod 2^PC_W. Pulse retire. Go to FETCH.
- run is sampled only in FETCH. Deasserting run mid-instruction does not stop the current instruction.
- ack inputs are ignored while the corresponding req is low.

## Timing
- Reset values:
  - pc=0, IR=0, alu_q=0, mdr=0, all registers 0, state FETCH.
  - imem_req=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, retire=0, rs_data=rt_data=0.
- imem_req and dmem_req are combinational from state (and run). Once raised, req, addr, we and wdata stay stable until the ack cycle inclusive.
- Ack in the same cycle as req (zero-wait memory) is legal.
- Zero-wait latency: ALU/addi = 3 cycles (FETCH, EXEC, WB); load/store = 4 cycles. Each wait cycle on an ack adds 1 cycle.
- Register write and pc increment take effect at the WB clock edge. retire is high during the WB cycle.
- rs_data and rt_data are combinational reads. A register written in WB is visible from the next cycle.
- Reset mid-operation: all state clears immediately and any req drops asynchronously. An outstanding transaction is abandoned. After reset release, the first fetch is from address 0.

## Configuration
- SIC4_SIGNED_IMM_EN defined: imm is sign-extended from 2 bits, range −2..+1.
- SIC4_SIGNED_IMM_EN undefined: imm is zero-extended, range 0..3 (single-cycle compatible).

## Test plan
- ALU sequence (DATA_W=8, zero-wait memories, run=1): imem = 0x41, 0x51, 0x14 -> r0=1, r1=2, then r1=4. retire high in cycles 3, 6, 9; pc=3 afterwards.
- Store/load: from r0=1, r1=4, execute 0xC4 then 0xA5 with dmem_rdata=0x5A -> store cycle shows dmem_we=1, addr 0x04, wdata 0x01; load cycle shows addr 0x05; r2=0x5A.
- Wait states: imem_ack held off 3 cycles -> imem_req and imem_addr stay stable, no state change, retire delayed by exactly 3 cycles. Same check on dmem.
- Wrap: r0=0, r1=1, execute 0x11 -> r1=0xFF. Separately, pc=0xFF retiring an instruction -> pc=0x00.
- Immediate mode: r0=0, execute 0x43 -> r0=0x03 without SIC4_SIGNED_IMM_EN, r0=0xFF with it.
- Control:
  - run=0 -> imem_req stays 0 and pc stays constant.
  - Assert rst during MEM with dmem_ack withheld -> dmem_req falls in the same cycle, pc=0 and registers 0; after release, the fetch address is 0.
